// File: rtl/binary_game_core.sv
// Round-based binary-counting game engine: draws non-zero targets from a free-running
// LFSR, scores held matches as hits, counts timeouts as misses, and stops after ROUNDS.
module binary_game_core #(
  parameter int unsigned      WIDTH          = 8,
  parameter int unsigned      ROUNDS         = 10,
  parameter int unsigned      TIMEOUT_CYCLES = 0,
  parameter int unsigned      HOLD_CYCLES    = 1,
  parameter logic [WIDTH-1:0] LFSR_TAPS      = 8'hB8,
  parameter logic [WIDTH-1:0] LFSR_SEED      = 8'h01
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WIDTH-1:0]                switches,
  input  logic                            start,
  output logic [WIDTH-1:0]                target,
  output logic                            new_target,
  output logic                            target_valid,
  output logic                            hit,
  output logic                            miss,
  output logic [$clog2(ROUNDS+1)-1:0]     score,
  output logic [$clog2(ROUNDS+1)-1:0]     round,
  output logic                            game_over
);

  localparam int unsigned CW = $clog2(ROUNDS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 2);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] ROUNDS_C = CW'(ROUNDS);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic          TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  lfsr_q, lfsr_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic              new_target_q, new_target_d;
  logic              hit_q, hit_d;
  logic              miss_q, miss_d;
  logic [CW-1:0]     score_q, score_d;
  logic [CW-1:0]     round_q, round_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              match_s;
  logic              hit_now_s;
  logic              miss_now_s;
  logic [CW-1:0]     round_inc_s;

  // State, LFSR and output registers; reset returns every output to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_SEED;
      target_q     <= '0;
      new_target_q <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      score_q      <= '0;
      round_q      <= '0;
      timer_q      <= '0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      target_q     <= target_d;
      new_target_q <= new_target_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      score_q      <= score_d;
      round_q      <= round_d;
      timer_q      <= timer_d;
      hold_q       <= hold_d;
    end
  end

  // Next-state and round bookkeeping.
  always_comb begin
    state_d      = state_q;
    lfsr_d       = {lfsr_q[WIDTH-2:0], ^(lfsr_q & LFSR_TAPS)};
    target_d     = target_q;
    new_target_d = 1'b0;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    score_d      = score_q;
    round_d      = round_q;
    timer_d      = timer_q;
    hold_d       = hold_q;
    match_s      = (switches == target_q);
    hit_now_s    = 1'b0;
    miss_now_s   = 1'b0;
    round_inc_s  = round_q + CW'(1);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          score_d = '0;
          round_d = '0;
          state_d = S_LOAD;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        // Refusing a target equal to the switches rules out an instant hit.
        if (lfsr_q != switches) begin
          target_d     = lfsr_q;
          timer_d      = '0;
          hold_d       = '0;
          new_target_d = 1'b1;
          state_d      = S_PLAY;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_PLAY: begin
        timer_d    = timer_q + TW'(1);
        hit_now_s  = match_s && (hold_q == H_LAST);
        miss_now_s = TO_EN && (timer_q == T_LAST) && !hit_now_s;
        if (match_s) begin
          hold_d = hold_q + HW'(1);
        end else begin
          hold_d = '0;
        end
        if (hit_now_s) begin
          hit_d   = 1'b1;
          score_d = score_q + CW'(1);
        end else begin
          score_d = score_q;
        end
        if (hit_now_s || miss_now_s) begin
          miss_d  = miss_now_s;
          round_d = round_inc_s;
          state_d = (round_inc_s == ROUNDS_C) ? S_DONE : S_LOAD;
        end else begin
          state_d = S_PLAY;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign target       = target_q;
  assign new_target   = new_target_q;
  assign hit          = hit_q;
  assign miss         = miss_q;
  assign score        = score_q;
  assign round        = round_q;
  assign target_valid = (state_q == S_PLAY);
  assign game_over    = (state_q == S_DONE);

endmodule

// File: tb/tb_binary_game_core.sv
// Directed bench for binary_game_core: instance A (ROUNDS=3, TIMEOUT=20, HOLD=1)
// and instance B (ROUNDS=3, TIMEOUT=0, HOLD=3) against an independent LFSR model.
module tb_binary_game_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw_a = 8'h00, sw_b = 8'h00;
  logic       st_a = 1'b0, st_b = 1'b0;

  logic [7:0] tgt_a, tgt_b;
  logic       nt_a, tv_a, hit_a, miss_a, go_a;
  logic       nt_b, tv_b, hit_b, miss_b, go_b;
  logic [1:0] score_a, round_a, score_b, round_b;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] m_lfsr = 8'h01;
  logic [7:0] m_prev = 8'h00;

  binary_game_core #(.WIDTH(8), .ROUNDS(3), .TIMEOUT_CYCLES(20), .HOLD_CYCLES(1),
                     .LFSR_TAPS(8'hB8), .LFSR_SEED(8'h01)) dut_a (
    .clk(clk), .rst(rst), .switches(sw_a), .start(st_a), .target(tgt_a),
    .new_target(nt_a), .target_valid(tv_a), .hit(hit_a), .miss(miss_a),
    .score(score_a), .round(round_a), .game_over(go_a)
  );

  binary_game_core #(.WIDTH(8), .ROUNDS(3), .TIMEOUT_CYCLES(0), .HOLD_CYCLES(3),
                     .LFSR_TAPS(8'hB8), .LFSR_SEED(8'h01)) dut_b (
    .clk(clk), .rst(rst), .switches(sw_b), .start(st_b), .target(tgt_b),
    .new_target(nt_b), .target_valid(tv_b), .hit(hit_b), .miss(miss_b),
    .score(score_b), .round(round_b), .game_over(go_b)
  );

  always #5 clk = ~clk;

  // Reference LFSR: feedback from bits 7,5,4,3 (mask 0xB8); m_prev is the pre-edge value.
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    if (rst) m_lfsr <= 8'h01;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a new_target pulse on A and checks the loaded target.
  task automatic wait_load_a(output int k, output logic [7:0] t);
    k = 0;
    while (!nt_a && k < 20) begin
      tick();
      k++;
    end
    chk("load_a_seen", {31'd0, nt_a}, 32'd1);
    chk("load_a_target", {24'd0, tgt_a}, {24'd0, m_prev});
    chk("load_a_nonzero", {31'd0, (tgt_a != 8'h00)}, 32'd1);
    t = m_prev;
  endtask

  initial begin
    int         k;
    logic [7:0] cur;
    logic [7:0] pre;

    // Reset state
    tick(); tick();
    chk("rst_outs_a", {14'd0, tgt_a, nt_a, tv_a, hit_a, miss_a, score_a, round_a, go_a}, 32'd0);
    chk("rst_outs_b", {14'd0, tgt_b, nt_b, tv_b, hit_b, miss_b, score_b, round_b, go_b}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic hit on A
    st_a = 1'b1;
    tick();
    st_a = 1'b0;
    chk("start_load_tv", {31'd0, tv_a}, 32'd0);
    chk("start_load_nt", {31'd0, nt_a}, 32'd0);
    tick();
    chk("first_nt", {31'd0, nt_a}, 32'd1);
    chk("first_tv", {31'd0, tv_a}, 32'd1);
    chk("first_target", {24'd0, tgt_a}, {24'd0, m_prev});
    cur  = m_prev;
    sw_a = cur;
    tick();
    chk("basic_hit", {28'd0, hit_a, miss_a, nt_a, tv_a}, 32'b1000);
    chk("basic_score_round", {28'd0, score_a, round_a}, {28'd0, 2'd1, 2'd1});
    pre = m_lfsr;
    wait_load_a(k, cur);
    chk("reload_gap", k, (pre != sw_a) ? 32'd1 : 32'd2);

    // Timeout: switches never match for 20 cycles
    sw_a = cur ^ 8'h01;
    repeat (19) tick();
    chk("pre_timeout", {29'd0, miss_a, round_a}, {29'd0, 1'b0, 2'd1});
    tick();
    chk("timeout_miss", {30'd0, hit_a, miss_a}, 32'b01);
    chk("timeout_counts", {27'd0, score_a, round_a, go_a}, {27'd0, 2'd1, 2'd2, 1'b0});
    tick();
    chk("miss_pulse_width", {31'd0, miss_a}, 32'd0);
    wait_load_a(k, cur);

    // Tie: first match on the timeout cycle -> hit wins, game ends
    sw_a = cur ^ 8'h01;
    repeat (19) tick();
    sw_a = cur;
    tick();
    chk("tie_hit_no_miss", {30'd0, hit_a, miss_a}, 32'b10);
    chk("game_end", {27'd0, score_a, round_a, go_a}, {27'd0, 2'd2, 2'd3, 1'b1});
    repeat (3) tick();
    chk("done_frozen", {25'd0, score_a, round_a, go_a, hit_a, tv_a}, {25'd0, 2'd2, 2'd3, 1'b1, 1'b0, 1'b0});

    // Restart from DONE
    st_a = 1'b1;
    tick();
    st_a = 1'b0;
    chk("restart_clear", {27'd0, score_a, round_a, go_a}, 32'd0);
    wait_load_a(k, cur);

    // Reset mid-game with start held
    st_a = 1'b1;
    rst  = 1'b1;
    tick();
    chk("midgame_rst", {14'd0, tgt_a, nt_a, tv_a, hit_a, miss_a, score_a, round_a, go_a}, 32'd0);
    tick();
    chk("rst_holds_start", {14'd0, tgt_a, nt_a, tv_a, hit_a, miss_a, score_a, round_a, go_a}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_load", {29'd0, nt_a, tv_a, go_a}, 32'd0);

    // Anti-instant-hit: switches equal the LFSR at the LOAD compare
    sw_a = m_lfsr;
    st_a = 1'b0;
    tick();
    chk("load_retry", {30'd0, nt_a, tv_a}, 32'd0);
    tick();
    chk("retry_loaded", {31'd0, nt_a}, 32'd1);
    chk("retry_target", {24'd0, tgt_a}, {24'd0, m_prev});
    chk("retry_ne_sw", {31'd0, (tgt_a != sw_a)}, 32'd1);

    // 1000 loads against the model LFSR
    for (int i = 0; i < 1000; i++) begin
      wait_load_a(k, cur);
      sw_a = cur;
      tick();
      chk("loop_hit", {31'd0, hit_a}, 32'd1);
      if (go_a) begin
        st_a = 1'b1;
        tick();
        st_a = 1'b0;
      end
    end

    // Hold debounce on B (HOLD=3): match 2, mismatch 1, match 3
    st_b = 1'b1;
    tick();
    st_b = 1'b0;
    tick();
    chk("b_load", {31'd0, nt_b}, 32'd1);
    chk("b_target", {24'd0, tgt_b}, {24'd0, m_prev});
    cur  = m_prev;
    sw_b = cur;
    tick();
    tick();
    chk("b_two_matches", {31'd0, hit_b}, 32'd0);
    sw_b = cur ^ 8'h80;
    tick();
    chk("b_mismatch", {31'd0, hit_b}, 32'd0);
    sw_b = cur;
    tick();
    tick();
    chk("b_match_2of3", {31'd0, hit_b}, 32'd0);
    tick();
    chk("b_hit", {30'd0, hit_b, miss_b}, 32'b10);
    chk("b_counts", {28'd0, score_b, round_b}, {28'd0, 2'd1, 2'd1});
    tick();
    chk("b_single_pulse", {31'd0, hit_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/binary_game_core.md
# binary_game_core

Parametrised round-based engine for the binary-counting game. It draws a non-zero target from an internal free-running LFSR and waits for the DIP-switch value to match it and stay matched for a hold time. It scores hits, counts misses on timeout, and ends the game after a fixed number of rounds. It sits between the top-level switch inputs and the seven-segment display controller, driving that controller's value and trigger.

## Interface

Parameters:
- WIDTH, 8: switch/target width in bits (>= 2)
- ROUNDS, 10: rounds per game (>= 1)
- TIMEOUT_CYCLES, 0: cycles allowed per round; 0 disables timeout
- HOLD_CYCLES, 1: consecutive matching samples required for a hit (>= 1)
- LFSR_TAPS, 8'hB8 (WIDTH bits): feedback tap mask
- LFSR_SEED, 8'h01 (WIDTH bits): reset value, non-zero

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  synchronous active-high reset
- switches  in  WIDTH  player input, sampled every cycle
- start  in  1  level; begins a game when sampled high in IDLE or DONE
- target  out  WIDTH  current target; holds its value until the next load
- new_target  out  1  one-cycle pulse after each target load (display trigger)
- target_valid  out  1  high while in PLAY
- hit  out  1  one-cycle pulse after a scored round
- miss  out  1  one-cycle pulse after a timed-out round
- score  out  $clog2(ROUNDS+1)  hits in the current game
- round  out  $clog2(ROUNDS+1)  completed rounds in the current game
- game_over  out  1  high in DONE

## Operation

- LFSR advances every cycle from reset, independent of state: lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & LFSR_TAPS)}. It is never zero, so target is never zero.
- IDLE: outputs quiet. If start is sampled high, clear score and round and go to LOAD.
- LOAD: if lfsr != switches, latch target <= lfsr, clear timer and hold counter, assert new_target next cycle, and go to PLAY. Otherwise stay in LOAD; the LFSR has advanced and the comparison is retried next cycle. This guarantees no instant hit.
- PLAY:
  - timer increments each cycle.
  - hold counter increments while switches == target and resets to 0 on any mismatch.
  - Hit: match sampled and hold counter == HOLD_CYCLES-1. Score +1, round +1, hit pulse.
  - Miss: TIMEOUT_CYCLES != 0, timer == TIMEOUT_CYCLES-1, and no hit that cycle. Round +1, miss pulse.
  - After a hit or miss: if the new round == ROUNDS go to DONE, else go to LOAD.
  - Hit and timeout in the same cycle: hit wins, no miss.
  - start is ignored in PLAY and LOAD.
- DONE: game_over=1, and score and round frozen. If start is sampled high, clear score and round and go to LOAD directly.
- Counters never wrap: score <= round <= ROUNDS.

## Timing

- Reset values:
  - outputs: target=0, new_target=0, target_valid=0, hit=0, miss=0, score=0, round=0, game_over=0
  - internal: state=IDLE, lfsr=LFSR_SEED
- rst sampled high at any edge, including mid-PLAY, forces reset values at that edge with no pulses emitted. rst has priority over start.
- start sampled high at edge N (IDLE) -> LOAD during N..N+1. If the load is accepted at edge N+1: target valid, new_target=1 and target_valid=1 in cycle N+1..N+2.
- First switch sample counted toward the hold at edge N+2.
- With HOLD_CYCLES=H and switches matching from edge M onward: hit, score and round update at edge M+H-1. The hit pulse is visible in the following cycle, during which the state is LOAD (or DONE).
- Round-to-round minimum: 1 LOAD cycle plus the PLAY cycles.
- Timeout: with the load at edge L, the miss registers at edge L+TIMEOUT_CYCLES.
- Pulses (new_target, hit, miss) are exactly one cycle wide. hit and miss are never high together.

## Test plan

- Reset mid-game: WIDTH=8, ROUNDS=3; start, enter PLAY, assert rst one cycle -> next cycle all outputs 0, state IDLE, and a held start must not restart until rst is released.
- Basic hit: HOLD_CYCLES=1, TIMEOUT_CYCLES=0; drive switches=target one cycle after new_target -> hit pulse on the next cycle, score=1, round=1, new target loaded after 1 LOAD cycle.
- Hold debounce: HOLD_CYCLES=3; match 2 cycles, mismatch 1, match 3 -> a single hit exactly after the 3rd consecutive matching sample, score=1.
- Timeout and tie: TIMEOUT_CYCLES=20, switches never match -> miss at load+20, round=1, score=0. Then apply the first match on cycle 20 with HOLD_CYCLES=1 -> hit, no miss.
- Full game: ROUNDS=3 with hit/miss/hit -> score=2, round=3, game_over=1. Further matches change nothing; start -> score=0, round=0, new target loaded.
- LFSR and anti-instant-hit: compare target against a model LFSR (seed 0x01, taps 0xB8) over 1000 loads, never 0. Force switches equal to the LFSR value at LOAD -> LOAD lasts 2 cycles and target != switches.
